// File: rtl/load_aligner.sv
// Sequential load path: fetches one or two aligned memory words, splices a
// boundary-straddling access, then shifts and sign/zero-extends to 32 bits.
package load_aligner_pkg;
   typedef enum logic [2:0] {
      BYTE   = 3'b000,
      HALF   = 3'b001,
      WORD   = 3'b010,
      U_BYTE = 3'b100,
      U_HALF = 3'b101
   } load3_t;
endpackage

module load_aligner
   import load_aligner_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  load3_t                load3_i,
   output logic                  mem_req_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   input  logic                  mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   output logic                  valid_o,
   output logic [31:0]           data_o,
   output logic                  misaligned_o,
   output logic                  err_o
);
   localparam int BYTES = DATA_WIDTH / 8;
   localparam int OFF_W = $clog2(BYTES);

   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

   state_t                      r_state, w_state_nxt;
   logic   [ADDR_WIDTH-1:0]     r_addr;
   load3_t                      r_type;
   logic                        r_split;
   logic   [DATA_WIDTH-1:0]     r_lo;
   logic   [31:0]               r_data;
   logic                        r_mis, r_err;

   logic                        w_ld_lo, w_ld_res, w_ld_err;
   logic   [4:0]                w_req_end;
   logic   [OFF_W-1:0]          w_off;
   logic   [ADDR_WIDTH-1:0]     w_aligned, w_hi_addr;
   logic   [2*DATA_WIDTH-1:0]   w_pair;
   logic   [31:0]               w_raw, w_result;

   function automatic logic [2:0] size_of(input load3_t t);
      case (t)
         BYTE, U_BYTE: size_of = 3'd1;
         HALF, U_HALF: size_of = 3'd2;
         WORD:         size_of = 3'd4;
         default:      size_of = 3'd0;
      endcase
   endfunction

   function automatic logic [31:0] extend(input logic [31:0] raw, input load3_t t);
      case (t)
         BYTE:    extend = {{24{raw[7]}}, raw[7:0]};
         HALF:    extend = {{16{raw[15]}}, raw[15:0]};
         U_BYTE:  extend = {24'd0, raw[7:0]};
         U_HALF:  extend = {16'd0, raw[15:0]};
         default: extend = raw;
      endcase
   endfunction

   assign w_req_end = 5'(req_addr_i[OFF_W-1:0]) + 5'(size_of(load3_i));
   assign w_off     = r_addr[OFF_W-1:0];
   assign w_aligned = r_addr & ~ADDR_WIDTH'(BYTES - 1);
   assign w_hi_addr = w_aligned + ADDR_WIDTH'(BYTES);

   // Upper word is zero unless this is the second beat of a split access
   assign w_pair   = (r_state == BEAT1) ? {mem_rdata_i, r_lo}
                                        : {{DATA_WIDTH{1'b0}}, mem_rdata_i};
   assign w_raw    = 32'(w_pair >> {w_off, 3'b000});
   assign w_result = extend(w_raw, r_type);

   always_comb begin
      w_state_nxt = r_state;
      req_ready_o = 1'b0;
      mem_req_o   = 1'b0;
      mem_addr_o  = '0;
      valid_o     = 1'b0;
      w_ld_lo     = 1'b0;
      w_ld_res    = 1'b0;
      w_ld_err    = 1'b0;
      case (r_state)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               if (size_of(load3_i) != 3'd0) begin
                  w_state_nxt = BEAT0;
               end else begin
                  w_state_nxt = RESP;
                  w_ld_err    = 1'b1;
               end
            end
         end
         BEAT0: begin
            mem_req_o  = 1'b1;
            mem_addr_o = w_aligned;
            if (mem_rvalid_i) begin
               if (r_split) begin
                  w_state_nxt = BEAT1;
                  w_ld_lo     = 1'b1;
               end else begin
                  w_state_nxt = RESP;
                  w_ld_res    = 1'b1;
               end
            end
         end
         BEAT1: begin
            mem_req_o  = 1'b1;
            mem_addr_o = w_hi_addr;
            if (mem_rvalid_i) begin
               w_state_nxt = RESP;
               w_ld_res    = 1'b1;
            end
         end
         RESP: begin
            valid_o     = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_split <= 1'b0;
         r_data  <= '0;
         r_mis   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == IDLE && req_valid_i) begin
            r_split <= (w_req_end > 5'(BYTES));
         end
         if (w_ld_res) begin
            r_data <= w_result;
            r_mis  <= r_split;
            r_err  <= 1'b0;
         end else if (w_ld_err) begin
            r_data <= '0;
            r_mis  <= 1'b0;
            r_err  <= 1'b1;
         end
      end
   end

   // Datapath holding registers; only meaningful once the FSM has loaded them
   always_ff @(posedge clk) begin
      if (r_state == IDLE && req_valid_i) begin
         r_addr <= req_addr_i;
         r_type <= load3_i;
      end
      if (w_ld_lo) begin
         r_lo <= mem_rdata_i;
      end
   end

   assign data_o       = r_data;
   assign misaligned_o = r_mis;
   assign err_o        = r_err;

endmodule

// File: doc/load_aligner.md
# load_aligner

Sequential load-path successor to the combinational byte selector. It takes a load request (byte address plus `load3_t` type), fetches one or two naturally aligned words over a parametrised memory data bus, and splices words when an access straddles a word boundary. It then shifts and sign- or zero-extends the result to 32 bits and returns it with a single-cycle valid pulse. It sits between the execute stage's load request and the data-memory port.

## Interface
Parameters:
- `DATA_WIDTH`, 32, memory bus width in bits; legal values 32 or 64; `BYTES = DATA_WIDTH/8`.
- `ADDR_WIDTH`, 32, byte-address width.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid_i`  in  1  load request valid.
- `req_ready_o`  out  1  high only in IDLE; a request is accepted when `req_valid_i & req_ready_o`.
- `req_addr_i`  in  ADDR_WIDTH  byte address of the load.
- `load3_i`  in  load3_t  load type: BYTE, HALF, WORD, U_BYTE or U_HALF; any other encoding is illegal.
- `mem_req_o`  out  1  memory read request.
- `mem_addr_o`  out  ADDR_WIDTH  word-aligned read address; low log2(BYTES) bits are always 0.
- `mem_rvalid_i`  in  1  read data valid; may arrive in the same cycle as `mem_req_o`.
- `mem_rdata_i`  in  DATA_WIDTH  read data, little-endian.
- `valid_o`  out  1  one-cycle result pulse.
- `data_o`  out  32  extended load result; holds its value until the next response.
- `misaligned_o`  out  1  the last response needed two beats; valid with `valid_o` and held.
- `err_o`  out  1  the last request had an illegal `load3_i`; valid with `valid_o` and held.

## Operation
- FSM states: IDLE, BEAT0, BEAT1, RESP.
- Access size: 1 byte for BYTE/U_BYTE, 2 for HALF/U_HALF, 4 for WORD.
- Byte offset: `off = addr mod BYTES`.
- Split condition: `off + size > BYTES`.
- IDLE, on accept of a legal type: latch the address, type and split flag, then go to BEAT0.
- IDLE, on accept of an illegal type: go to RESP with `data_o=0` and `err_o=1`; no memory access is made.
- BEAT0: drive `mem_req_o=1` and `mem_addr_o = addr & ~(BYTES-1)`.
  - Hold both outputs until `mem_rvalid_i`, then capture `lo = mem_rdata_i`.
  - If split, go to BEAT1; otherwise compute the result and go to RESP.
- BEAT1: drive `mem_req_o=1` and `mem_addr_o = aligned addr + BYTES`, wrapping modulo 2^ADDR_WIDTH.
  - On `mem_rvalid_i`, capture `hi`, compute the result and go to RESP.
- Result computation:
  - Form `{hi, lo}`, with `hi` treated as 0 when not split.
  - Shift right by `off*8` and take the low `size*8` bits.
  - Sign-extend for BYTE/HALF; zero-extend for U_BYTE, U_HALF and WORD.
  - Register the result into `data_o` together with `misaligned_o` and `err_o`.
- RESP: `valid_o=1` for exactly one cycle, then return to IDLE.
- `mem_rvalid_i` is ignored outside BEAT0 and BEAT1.
- `mem_req_o` is 0 in IDLE and RESP.

## Timing
- Reset values: state IDLE, `req_ready_o=1`, `mem_req_o=0`, `mem_addr_o=0`, `valid_o=0`, `data_o=0`, `misaligned_o=0`, `err_o=0`.
- Reset asserted mid-operation (any state) clears everything immediately. The pending beat is abandoned, and a late `mem_rvalid_i` after reset is ignored.
- Latency with accept at cycle T and zero-wait memory (`mem_rvalid_i` in the same cycle as `mem_req_o`):
  - Aligned access: `mem_req_o` at T+1, `valid_o` at T+2.
  - Split access: beats at T+1 and T+2, `valid_o` at T+3.
  - Illegal type: `valid_o` at T+1.
- Each wait cycle (`mem_req_o` high, `mem_rvalid_i` low) adds one cycle of latency. `mem_addr_o` stays stable throughout.
- No request is accepted from BEAT0 through RESP. The next accept is possible in the cycle after RESP.
- Throughput: at most one load per 3 cycles aligned, or per 4 cycles split.

## Test plan
- Aligned WORD, DATA_WIDTH=32: addr 0x100, memory returns 0x8899AABB with zero wait.
  - Required: one beat at 0x100; `data_o=0x8899AABB`, `misaligned_o=0`, `valid_o` at T+2.
- BYTE at 0x103 with word 0x80123456:
  - Required: `data_o=0xFFFFFF80`.
  - Same access as U_BYTE: `data_o=0x00000080`.
- Split HALF at 0x203: beat0 at 0x200 returns 0x11223344; beat1 at 0x204 returns 0x55667788.
  - Required: `data_o=0xFFFF8811`, `misaligned_o=1`, `valid_o` at T+3.
- DATA_WIDTH=64, WORD at 0x0C: one beat at 0x08 returns 0x1122334455667788.
  - Required: `data_o=0x11223344`, not split.
- Wait states and reset: `mem_rvalid_i` delayed 3 cycles in BEAT0.
  - Required: `mem_req_o` and `mem_addr_o` held stable throughout.
  - Then assert `rst` during BEAT1. Required: all outputs at reset values immediately; a following stray `mem_rvalid_i` produces no `valid_o`; a new request is accepted normally.
- Address wrap: WORD at 0xFFFFFFFE (DATA_WIDTH=32).
  - Required: beats at 0xFFFFFFFC then 0x00000000.
- Illegal type: an illegal `load3_i` encoding.
  - Required: no `mem_req_o`; `valid_o` at T+1 with `data_o=0` and `err_o=1`.
